// File: rtl/ro_puf_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the ring-oscillator PUF core: FSM states,
// challenge-index width and the behavioural oscillator half-period table.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } puf_state_e;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

`ifndef SYNTHESIS
  // Half-periods in ns for a 15-stage cell; cells 0 and 1 are pinned to known values.
  function automatic real ro_half_ns(input int idx);
    case (idx)
      0:       return 1.0;
      1:       return 1.25;
      default: return 1.05 + 0.02 * real'(idx);
    endcase
  endfunction
`endif

endpackage

// File: rtl/ro_puf_core_cell.sv
`timescale 1ns/1ps
// One ring-oscillator cell: STAGES inverting stages closed through an enable
// NAND, plus a saturating edge counter clocked by the oscillator itself.
module ro_cell
  import ro_puf_pkg::*;
#(
  parameter int STAGES = 15,
  parameter int CNT_W  = 16,
  parameter int IDX    = 0
) (
  input  logic             en_i,
  input  logic             clr_n_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             ro_s;
  logic [CNT_W-1:0] cnt_q;

`ifdef SYNTHESIS
  (* dont_touch = "true" *) logic [STAGES-1:0] chain_s;

  assign chain_s[0] = ~(en_i & chain_s[STAGES-1]);
  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    assign chain_s[g] = ~chain_s[g-1];
  end
  assign ro_s = chain_s[STAGES-1];
`else
  // Behavioural ring: period scales with stage count relative to the 15-stage table.
  always begin
    if (en_i == 1'b1) begin
      #(ro_half_ns(IDX) * real'(STAGES) / 15.0);
      ro_s = (en_i == 1'b1) ? ~ro_s : 1'b0;
    end else begin
      ro_s = 1'b0;
      @(posedge en_i);
    end
  end
`endif

  // Oscillator-domain counter; cleared asynchronously since the ring is stopped while clearing.
  always_ff @(posedge ro_s or negedge clr_n_i) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_puf_core.sv
`timescale 1ns/1ps
// Ring-oscillator PUF core: races two selected oscillators for a fixed clk
// window, lets them stop, then compares their captured edge counts.
module ro_puf_core
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO = 16,
  parameter int STAGES = 15,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [sel_w(NUM_RO)-1:0]  chal_a,
  input  logic [sel_w(NUM_RO)-1:0]  chal_b,
  output logic                      busy,
  output logic                      done,
  output logic                      response,
  output logic                      tie,
  output logic                      err,
  output logic                      ovf,
  output logic [CNT_W-1:0]          count_a,
  output logic [CNT_W-1:0]          count_b
);

  localparam int               SEL_W   = sel_w(NUM_RO);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  puf_state_e        state_q, state_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [SEL_W-1:0]  chal_a_q, chal_a_d, chal_b_q, chal_b_d;
  logic [NUM_RO-1:0] en_q, en_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              reject_s, chal_ok_s, clr_n_s;
  logic [CNT_W-1:0]  cnt_s [NUM_RO];
  logic [CNT_W-1:0]  cap_a_s, cap_b_s;
  logic              done_q, response_q, tie_q, err_q, ovf_q;
  logic [CNT_W-1:0]  count_a_q, count_b_q;

  assign chal_ok_s = (chal_a != chal_b) && (int'(chal_a) < NUM_RO) && (int'(chal_b) < NUM_RO);
  assign clr_n_s   = rst_n & ~clr_q;

  for (genvar g = 0; g < NUM_RO; g++) begin : g_cell
    ro_cell #(
      .STAGES (STAGES),
      .CNT_W  (CNT_W),
      .IDX    (g)
    ) u_cell (
      .en_i    (en_q[g]),
      .clr_n_i (clr_n_s),
      .cnt_o   (cnt_s[g])
    );
  end

  // Counts are only sampled in CAPTURE, after the rings have been stopped for SETTLE cycles.
  assign cap_a_s = cnt_s[chal_a_q];
  assign cap_b_s = cnt_s[chal_b_q];

  // Next-state logic for the evaluation sequence.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    chal_a_d = chal_a_q;
    chal_b_d = chal_b_q;
    reject_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (chal_ok_s) begin
            state_d  = ST_CLEAR;
            cyc_d    = 32'd0;
            chal_a_d = chal_a;
            chal_b_d = chal_b;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cyc_q == 32'd1) begin
          state_d = ST_RUN;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_RUN: begin
        if (cyc_q == 32'(WINDOW - 1)) begin
          state_d = ST_SETTLE;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (cyc_q == 32'(SETTLE - 1)) begin
          state_d = ST_CAPTURE;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        cyc_d   = 32'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 32'd0;
      end
    endcase
  end

  // Enables and clear are decoded from the next state so the registered versions track the state exactly.
  always_comb begin
    en_d   = '0;
    clr_d  = (state_d == ST_CLEAR);
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_RUN) begin
      en_d[chal_a_q] = 1'b1;
      en_d[chal_b_q] = 1'b1;
    end else begin
      en_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 32'd0;
      chal_a_q <= '0;
      chal_b_q <= '0;
      en_q     <= '0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      chal_a_q <= chal_a_d;
      chal_b_q <= chal_b_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
    end
  end

  // Result registers: loaded on CAPTURE or a rejected challenge, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
    end else begin
      done_q <= (state_q == ST_CAPTURE) || reject_s;
      if (state_q == ST_CAPTURE) begin
        count_a_q  <= cap_a_s;
        count_b_q  <= cap_b_s;
        response_q <= (cap_a_s > cap_b_s);
        tie_q      <= (cap_a_s == cap_b_s);
        err_q      <= 1'b0;
        ovf_q      <= (cap_a_s == CNT_MAX) || (cap_b_s == CNT_MAX);
      end else if (reject_s) begin
        response_q <= 1'b0;
        tie_q      <= 1'b0;
        err_q      <= 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie      = tie_q;
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;

endmodule
